writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter_pkg.sv | 9 +
 rtl/writeback_arbiter_if.sv | 28 ++
 rtl/writeback_arbiter_rr_arbiter.sv | 26 ++
 rtl/writeback_arbiter.sv | 57 +++++
 tb/tb_writeback_arbiter.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg: shared register width, source count, source indices and register address type
package writeback_arbiter_pkg;
  localparam int XLEN = 64;
  localparam int NUM_SRC = 3;
  localparam int SRC_ALU = 0;
  localparam int SRC_MUL = 1;
  localparam int SRC_LSU = 2;
  typedef logic [4:0] reg_addr_t;
endpackage

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: issue, result-source and register-file write bundle
//   issue_*  : instruction issue (sets scoreboard bit)
//   src_*    : per-source result valid/ready handshake with rd and data
//   rd_addr_o/wr_en_o/wr_data_o : registered register-file write port
//   busy_o   : scoreboard of registers with a pending write
interface writeback_arbiter_if #(
  parameter int XLEN = writeback_arbiter_pkg::XLEN,
  parameter int NUM_SRC = writeback_arbiter_pkg::NUM_SRC
);
  logic issue_valid_i;
  writeback_arbiter_pkg::reg_addr_t issue_rd_i;
  logic [NUM_SRC-1:0] src_valid_i;
  writeback_arbiter_pkg::reg_addr_t [NUM_SRC-1:0] src_rd_i;
  logic [NUM_SRC-1:0][XLEN-1:0] src_data_i;
  logic [NUM_SRC-1:0] src_ready_o;
  writeback_arbiter_pkg::reg_addr_t rd_addr_o;
  logic wr_en_o;
  logic [XLEN-1:0] wr_data_o;
  logic [31:0] busy_o;
  modport master (
    output issue_valid_i, issue_rd_i, src_valid_i, src_rd_i, src_data_i,
    input src_ready_o, rd_addr_o, wr_en_o, wr_data_o, busy_o
  );
  modport slave (
    input issue_valid_i, issue_rd_i, src_valid_i, src_rd_i, src_data_i,
    output src_ready_o, rd_addr_o, wr_en_o, wr_data_o, busy_o
  );
endinterface

// File: rtl/writeback_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant starting at ptr, one-hot gnt and pointer past the winner
//   req : request vector   ptr : search start   gnt : one-hot grant   nxt : next pointer (ptr if idle)
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] nxt
);
  logic [N-1:0] rot;
  logic [2*N-1:0] hot;
  // rotate so ptr sits at bit 0, pick lowest set bit, rotate the grant back
  always_comb begin
    rot = N'({req, req} >> ptr);
    hot = '0;
    nxt = ptr;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) begin
        hot = (2*N)'(1) << (int'(ptr) + k);
        nxt = PW'((int'(ptr) + k + 1) % N);
      end
    gnt = hot[N-1:0] | hot[2*N-1:N];
  end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: round-robin result writeback into the register file with a busy scoreboard
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : writeback_arbiter_if.slave (issue, sources, write port, busy)
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int XLEN = writeback_arbiter_pkg::XLEN,
  parameter int NUM_SRC = writeback_arbiter_pkg::NUM_SRC
) (
  input logic clk,
  input logic reset_n,
  writeback_arbiter_if.slave bus
);
  localparam int PW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  logic [PW-1:0] rr_ptr, rr_nxt;
  logic [NUM_SRC-1:0] gnt;
  reg_addr_t sel_rd, rd_addr;
  logic [XLEN-1:0] sel_data, wr_data;
  logic xfer, wr_en, do_wr;
  logic [31:0] clr, set, busy;
  rr_arbiter #(.N(NUM_SRC)) u_rr (.req(bus.src_valid_i), .ptr(rr_ptr), .gnt(gnt), .nxt(rr_nxt));
  assign bus.src_ready_o = reset_n ? gnt : '0;
  assign xfer = |bus.src_ready_o;
  always_comb begin
    sel_rd = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_rd |= {5{gnt[i]}} & bus.src_rd_i[i];
      sel_data |= {XLEN{gnt[i]}} & bus.src_data_i[i];
    end
  end
  // x0 results are accepted but never written; set beats clear on the same bit
  assign do_wr = xfer && sel_rd != '0;
  assign clr = xfer ? 32'd1 << sel_rd : '0;
  assign set = (bus.issue_valid_i && bus.issue_rd_i != '0) ? 32'd1 << bus.issue_rd_i : '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rr_ptr <= '0;
      wr_en <= 1'b0;
      rd_addr <= '0;
      wr_data <= '0;
      busy <= '0;
    end else begin
      rr_ptr <= rr_nxt;
      wr_en <= do_wr;
      if (do_wr) begin
        rd_addr <= sel_rd;
        wr_data <= sel_data;
      end
      busy <= ((busy & ~clr) | set) & ~32'd1;
    end
  assign bus.wr_en_o = wr_en;
  assign bus.rd_addr_o = rd_addr;
  assign bus.wr_data_o = wr_data;
  assign bus.busy_o = busy;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed and random checks of writeback_arbiter against a reference model
module tb_writeback_arbiter;
  localparam int XLEN = 64;
  localparam int NUM_SRC = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  writeback_arbiter_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC)) bus ();
  writeback_arbiter #(.XLEN(XLEN), .NUM_SRC(NUM_SRC)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  int checks = 0;
  int fails = 0;
  int m_ptr, m_g;
  bit [31:0] m_busy;
  bit m_wr;
  bit [4:0] m_addr;
  bit [63:0] m_data;
  logic [NUM_SRC-1:0] last_ready;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int grant_of(input logic [NUM_SRC-1:0] v, input int p);
    for (int k = 0; k < NUM_SRC; k++)
      if (v[(p + k) % NUM_SRC]) return (p + k) % NUM_SRC;
    return -1;
  endfunction
  task automatic model_reset();
    m_ptr = 0;
    m_busy = '0;
    m_wr = 0;
    m_addr = '0;
    m_data = '0;
  endtask
  task automatic set_src(input int i, input bit v, input bit [4:0] rd, input bit [63:0] d);
    bus.src_valid_i[i] = v;
    bus.src_rd_i[i] = rd;
    bus.src_data_i[i] = d;
  endtask
  task automatic idle();
    bus.issue_valid_i = 1'b0;
    bus.issue_rd_i = '0;
    for (int i = 0; i < NUM_SRC; i++) set_src(i, 1'b0, 5'd0, 64'd0);
  endtask
  // one clock: check ready mid-cycle, advance the model across the edge, check the write port
  task automatic cyc(input string tag);
    #2;
    m_g = grant_of(bus.src_valid_i, m_ptr);
    last_ready = bus.src_ready_o;
    chk({tag, ".ready"}, 64'(bus.src_ready_o), m_g < 0 ? 64'd0 : 64'd1 << m_g);
    @(posedge clk);
    #1;
    m_wr = 0;
    if (m_g >= 0) begin
      m_ptr = (m_g + 1) % NUM_SRC;
      if (bus.src_rd_i[m_g] != 0) begin
        m_wr = 1;
        m_addr = bus.src_rd_i[m_g];
        m_data = bus.src_data_i[m_g];
      end
      m_busy[bus.src_rd_i[m_g]] = 1'b0;
    end
    if (bus.issue_valid_i && bus.issue_rd_i != 0) m_busy[bus.issue_rd_i] = 1'b1;
    m_busy[0] = 1'b0;
    chk({tag, ".wr_en"}, 64'(bus.wr_en_o), 64'(m_wr));
    chk({tag, ".rd_addr"}, 64'(bus.rd_addr_o), 64'(m_addr));
    chk({tag, ".wr_data"}, bus.wr_data_o, m_data);
    chk({tag, ".busy"}, 64'(bus.busy_o), 64'(m_busy));
  endtask
  initial begin
    idle();
    model_reset();
    bus.src_valid_i = 3'b111;
    #1;
    chk("rst.ready", 64'(bus.src_ready_o), 64'd0);
    chk("rst.wr_en", 64'(bus.wr_en_o), 64'd0);
    chk("rst.rd_addr", 64'(bus.rd_addr_o), 64'd0);
    chk("rst.wr_data", bus.wr_data_o, 64'd0);
    chk("rst.busy", 64'(bus.busy_o), 64'd0);
    @(posedge clk);
    #1;
    idle();
    reset_n = 1'b1;
    set_src(0, 1'b1, 5'd5, 64'hDEAD_BEEF);
    cyc("alu");
    chk("alu.ready_lit", 64'(last_ready), 64'd1);
    chk("alu.wr_en_lit", 64'(bus.wr_en_o), 64'd1);
    chk("alu.addr_lit", 64'(bus.rd_addr_o), 64'd5);
    chk("alu.data_lit", bus.wr_data_o, 64'hDEAD_BEEF);
    idle();
    cyc("alu_after");
    chk("alu_after.wr_en_lit", 64'(bus.wr_en_o), 64'd0);
    set_src(1, 1'b1, 5'd9, 64'h1234);
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i = 5'd12;
    cyc("pre_rst");
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst.wr_en", 64'(bus.wr_en_o), 64'd0);
    chk("mid_rst.busy", 64'(bus.busy_o), 64'd0);
    chk("mid_rst.ready", 64'(bus.src_ready_o), 64'd0);
    idle();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc("post_rst");
    for (int i = 0; i < NUM_SRC; i++) set_src(i, 1'b1, 5'(i + 1), 64'(8'h11 * (i + 1)));
    for (int k = 0; k < 3; k++) begin
      cyc("contend");
      chk("contend.order", 64'(last_ready), 64'd1 << k);
      chk("contend.b2b", 64'(bus.wr_en_o), 64'd1);
    end
    set_src(1, 1'b0, 5'd0, 64'd0);
    for (int k = 0; k < 6; k++) begin
      cyc("fair");
      chk("fair.order", 64'(last_ready), (k % 2) == 0 ? 64'd1 : 64'd4);
    end
    idle();
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i = 5'd20;
    cyc("issue20");
    idle();
    set_src(2, 1'b1, 5'd0, 64'hFFFF);
    cyc("x0");
    chk("x0.ready_lit", 64'(last_ready), 64'd4);
    chk("x0.wr_en_lit", 64'(bus.wr_en_o), 64'd0);
    chk("x0.busy_lit", 64'(bus.busy_o), 64'd1 << 20);
    idle();
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i = 5'd7;
    cyc("sb_issue");
    chk("sb_issue.bit7", 64'(bus.busy_o[7]), 64'd1);
    set_src(0, 1'b1, 5'd7, 64'h77);
    cyc("sb_both");
    chk("sb_both.bit7", 64'(bus.busy_o[7]), 64'd1);
    bus.issue_valid_i = 1'b0;
    cyc("sb_clear");
    chk("sb_clear.bit7", 64'(bus.busy_o[7]), 64'd0);
    for (int n = 0; n < 400; n++) begin
      bus.issue_valid_i = 1'($urandom);
      bus.issue_rd_i = 5'($urandom);
      for (int i = 0; i < NUM_SRC; i++)
        set_src(i, 1'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), {$urandom, $urandom});
      cyc("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
